// File: rtl/bus_arbiter_pkg.sv
// s1c88 external bus types: CPU/memory bus commands and arbiter ownership states.
package s1c88_bus_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      IRQ_READ  = 2'd1,
      MEM_WRITE = 2'd2,
      MEM_READ  = 2'd3
   } bus_command_t;

   typedef enum logic [1:0] {
      OWN_CPU = 2'd0,
      OWN_REQ = 2'd1,
      TURN    = 2'd2
   } arb_state_t;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 8;

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus bundle between CPU, secondary masters, memory and the arbiter.
// req_lock exists only when BUS_ARB_LOCK_EN is defined.
interface bus_arbiter_if #(
   parameter int NUM_REQ = 2
);
   import s1c88_bus_pkg::*;

   bus_command_t             cpu_bus_status;
   logic [ADDR_W-1:0]        cpu_address;
   logic [DATA_W-1:0]        cpu_data_out;
   logic                     cpu_hold;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_we;
   logic [ADDR_W*NUM_REQ-1:0] req_address;
   logic [DATA_W*NUM_REQ-1:0] req_wdata;
   logic [NUM_REQ-1:0]       req_ack;
   logic [DATA_W-1:0]        req_rdata;
   bus_command_t             mem_bus_status;
   logic [ADDR_W-1:0]        mem_address;
   logic [DATA_W-1:0]        mem_wdata;
   logic [DATA_W-1:0]        mem_rdata;
`ifdef BUS_ARB_LOCK_EN
   logic [NUM_REQ-1:0]       req_lock;
`endif

   modport master (
      output cpu_bus_status, cpu_address, cpu_data_out,
      output req_valid, req_we, req_address, req_wdata,
      output mem_rdata,
`ifdef BUS_ARB_LOCK_EN
      output req_lock,
`endif
      input  cpu_hold, req_ack, req_rdata,
      input  mem_bus_status, mem_address, mem_wdata
   );

   modport slave (
      input  cpu_bus_status, cpu_address, cpu_data_out,
      input  req_valid, req_we, req_address, req_wdata,
      input  mem_rdata,
`ifdef BUS_ARB_LOCK_EN
      input  req_lock,
`endif
      output cpu_hold, req_ack, req_rdata,
      output mem_bus_status, mem_address, mem_wdata
   );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin picker: lowest requesting index at or above ptr, wrapping.
module rr_pick #(
   parameter int N     = 2,
   parameter int PTR_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic             any
);

   logic found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int j = 0; j < N; j++) begin
         if (!found && req[j] && j >= int'(ptr)) begin
            grant[j] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int j = 0; j < N; j++) begin
         if (!found && req[j]) begin
            grant[j] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/bus_arbiter.sv
// s1c88 bus arbiter: CPU default owner, round-robin secondaries, 2-clk bus cycle.
// Define BUS_ARB_LOCK_EN to add req_lock (owner keeps the bus while locked).
module bus_arbiter
   import s1c88_bus_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int MAX_WAIT = 8
) (
   input logic         clk,
   input logic         reset,
   bus_arbiter_if.slave bus
);

   localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   logic                ph;
   arb_state_t          state;
   logic                to_cpu;
   logic [PTR_W-1:0]    owner;
   logic [PTR_W-1:0]    ptr;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [WAIT_W-1:0]   wait_inc;
   logic [NUM_REQ-1:0]  win_oh;
   logic [NUM_REQ-1:0]  own_oh;
   logic [PTR_W-1:0]    win_idx;
   logic                any_req;
   logic                cpu_idle;
   logic                starved;
   logic [ADDR_W-1:0]   win_addr;
   logic [ADDR_W-1:0]   own_addr;
   logic [DATA_W-1:0]   win_wd;
   logic [DATA_W-1:0]   own_wd;
   logic                win_we;
   logic                own_we;
`ifdef BUS_ARB_LOCK_EN
   logic                own_locked;
`endif

   function automatic logic [PTR_W-1:0] next_ptr(
      input logic [PTR_W-1:0] i
   );
      return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
   endfunction

   rr_pick #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req   (bus.req_valid),
      .ptr   (ptr),
      .grant (win_oh),
      .any   (any_req)
   );

   assign cpu_idle = (bus.cpu_bus_status == IDLE);
   assign starved  = (wait_cnt == WAIT_W'(MAX_WAIT));
   assign wait_inc = starved ? wait_cnt : wait_cnt + 1'b1;

   // Field muxes for the fresh rr winner and for the latched owner.
   always_comb begin
      win_idx  = '0;
      win_addr = '0;
      win_wd   = '0;
      win_we   = 1'b0;
      own_oh   = '0;
      own_addr = '0;
      own_wd   = '0;
      own_we   = 1'b0;
`ifdef BUS_ARB_LOCK_EN
      own_locked = 1'b0;
`endif
      for (int j = 0; j < NUM_REQ; j++) begin
         if (win_oh[j]) begin
            win_idx  = PTR_W'(j);
            win_addr = bus.req_address[ADDR_W*j +: ADDR_W];
            win_wd   = bus.req_wdata[DATA_W*j +: DATA_W];
            win_we   = bus.req_we[j];
         end
         if (j == int'(owner)) begin
            own_oh[j] = 1'b1;
            own_addr  = bus.req_address[ADDR_W*j +: ADDR_W];
            own_wd    = bus.req_wdata[DATA_W*j +: DATA_W];
            own_we    = bus.req_we[j];
`ifdef BUS_ARB_LOCK_EN
            own_locked = bus.req_valid[j] & bus.req_lock[j];
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ph                 <= 1'b0;
         state              <= OWN_CPU;
         to_cpu             <= 1'b0;
         owner              <= '0;
         ptr                <= '0;
         wait_cnt           <= '0;
         bus.mem_bus_status <= IDLE;
         bus.mem_address    <= '0;
         bus.mem_wdata      <= '0;
         bus.cpu_hold       <= 1'b0;
         bus.req_ack        <= '0;
         bus.req_rdata      <= '0;
      end else begin
         ph <= ~ph;
         if (ph) begin
            if (state == OWN_REQ) begin
               bus.req_ack <= own_oh;
               if (bus.mem_bus_status == MEM_READ)
                  bus.req_rdata <= bus.mem_rdata;
            end
         end else begin
            bus.req_ack <= '0;
            unique case (state)
               OWN_CPU: begin
                  if (any_req && (cpu_idle || starved)) begin
                     state              <= TURN;
                     to_cpu             <= 1'b0;
                     owner              <= win_idx;
                     bus.mem_bus_status <= IDLE;
                     bus.cpu_hold       <= 1'b1;
                  end else begin
                     bus.mem_bus_status <= bus.cpu_bus_status;
                     bus.mem_address    <= bus.cpu_address;
                     bus.mem_wdata      <= bus.cpu_data_out;
                     bus.cpu_hold       <= 1'b0;
                     wait_cnt <= any_req ? wait_inc : '0;
                  end
               end
               TURN: begin
                  if (to_cpu) begin
                     state              <= OWN_CPU;
                     bus.mem_bus_status <= bus.cpu_bus_status;
                     bus.mem_address    <= bus.cpu_address;
                     bus.mem_wdata      <= bus.cpu_data_out;
                     bus.cpu_hold       <= 1'b0;
                     wait_cnt <= any_req ? wait_inc : '0;
                  end else begin
                     state              <= OWN_REQ;
                     bus.mem_bus_status <= own_we ? MEM_WRITE : MEM_READ;
                     bus.mem_address    <= own_addr;
                     bus.mem_wdata      <= own_wd;
                     bus.cpu_hold       <= 1'b1;
                     wait_cnt           <= '0;
                     ptr                <= next_ptr(owner);
                  end
               end
               OWN_REQ: begin
`ifdef BUS_ARB_LOCK_EN
                  if (own_locked) begin
                     bus.mem_bus_status <= own_we ? MEM_WRITE : MEM_READ;
                     bus.mem_address    <= own_addr;
                     bus.mem_wdata      <= own_wd;
                     bus.cpu_hold       <= 1'b1;
                     wait_cnt           <= '0;
                  end else
`endif
                  if (any_req && cpu_idle) begin
                     owner              <= win_idx;
                     bus.mem_bus_status <= win_we ? MEM_WRITE : MEM_READ;
                     bus.mem_address    <= win_addr;
                     bus.mem_wdata      <= win_wd;
                     bus.cpu_hold       <= 1'b1;
                     wait_cnt           <= '0;
                     ptr                <= next_ptr(win_idx);
                  end else begin
                     state              <= TURN;
                     to_cpu             <= 1'b1;
                     bus.mem_bus_status <= IDLE;
                     bus.cpu_hold       <= 1'b1;
                  end
               end
               default: state <= OWN_CPU;
            endcase
         end
      end
   end

endmodule
